id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register directly upstream of the ALU.
- Captures decoded operands and control with a valid/ready handshake, and supports stall and flush.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Drives the ALU's a, b and alu_ctrl inputs; ALU codes are 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- rs1_addr, rs2_addr, rd_addr  in  RA_W  source and destination register indices.
- rs1_data, rs2_data  in  XLEN  register file read data.
- imm  in  XLEN  sign-extended immediate.
- use_imm  in  1  b selects imm instead of rs2.
- alu_ctrl_in  in  4  ALU operation code.
- reg_write_in  in  1  instruction writes rd.
- flush  in  1  kill held/incoming instruction (branch mispredict).
- exmem_we, memwb_we  in  1  forwarding source write enables.
- exmem_rd, memwb_rd  in  RA_W  forwarding source destinations.
- exmem_result, memwb_result  in  XLEN  forwarding source data.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  execute stage consumes this cycle.
- a, b  out  XLEN  ALU operands.
- alu_ctrl  out  4  ALU operation.
- rd_out  out  RA_W  destination passed downstream.
- reg_write_out  out  1  write enable passed downstream, gated by out_valid.

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all held registers 0; alu_ctrl=0000; rd_out=0; reg_write_out=0; a=b=0. Reset mid-transaction discards the held instruction.
- in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
- Capture: at the edge where in_valid && in_ready && !flush, latch all inputs and set out_valid=1.
- Latency: one cycle from capture to out_valid.
- Consume without new capture: out_valid && out_ready && !(in_valid && in_ready) -> out_valid=0 next edge.
- Hold: out_valid && !out_ready -> all fields held, except operand refresh (below).
- Flush: has priority over capture and hold. Next edge out_valid=0 and reg_write_out=0; the incoming instruction is dropped the same cycle. Data registers may retain values.
- Forwarding mux is combinational on held rs1/rs2, per source:
  - Use exmem_result if exmem_we && exmem_rd!=0 && exmem_rd==held addr.
  - Else use memwb_result if the same conditions hold for memwb.
  - Else use the held data.
  - EX/MEM has priority over MEM/WB. Index 0 is never forwarded.
- a = forwarded rs1.
- b = use_imm_q ? imm_q : forwarded rs2. rs2 forwarding is still computed when use_imm_q=1, but does not affect b.
- Operand refresh: on each edge while holding and not flushing, the held rs1_data and rs2_data registers load their forwarded values. A stalled instruction therefore keeps results whose producers retire during the stall.
- Simultaneous consume and capture in one cycle: the new instruction replaces the old; out_valid stays 1.
- alu_ctrl is passed through unmodified; codes 0101–1111 are forwarded as-is for the ALU to handle.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding mux and operand refresh as above.
- Undefined: a = held rs1_data; b = use_imm_q ? imm_q : held rs2_data. Forwarding ports remain present but are ignored, and no refresh occurs. Software or an interlock must avoid RAW hazards.

Test Plan:
- Reset then capture rs1_data=10, rs2_data=5, alu_ctrl_in=0001, use_imm=0, out_ready=1 -> next cycle out_valid=1, a=10, b=5, alu_ctrl=0001; following cycle out_valid=0 if in_valid=0.
- Captured rs1_addr=3, rs1_data=1; exmem_we=1, exmem_rd=3, exmem_result=0xA; memwb_we=1, memwb_rd=3, memwb_result=0xB -> a=0xA. With exmem_we=0 -> a=0xB. With rs1_addr=0 -> a=1. With macro undefined -> a=1 in all cases.
- Stall: out_ready=0 with held rs2_addr=4, b from rs2; one-cycle pulse memwb_we=1, memwb_rd=4, memwb_result=0x55, then out_ready=1 -> b=0x55 after the pulse ends; in_ready=0 during the stall.
- Back-to-back: in_valid=1 and out_ready=1 every cycle, three instructions with alu_ctrl 0000, 0010, 0100 -> alu_ctrl sequence 0000, 0010, 0100 on consecutive cycles, no bubbles.
- Flush while holding, with a simultaneous in_valid=1 -> next cycle out_valid=0 and reg_write_out=0; the incoming instruction is not captured.
- Assert rst_n=0 mid-hold with out_valid=1 -> out_valid, a, b and alu_ctrl go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : Decode-to-execute pipeline register feeding the ALU. Captures
//             decoded operands and control with a valid/ready handshake,
//             supports stall and flush, and (optionally) resolves RAW hazards
//             by forwarding from the EX/MEM and MEM/WB stages.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Build option:
//    ID_EX_FORWARD_EN  defined   -> forwarding mux plus operand refresh while
//                                   the stage is stalled.
//                      undefined -> operands come straight from the held
//                                   registers; forwarding ports are ignored.
// ----------------------------------------------------------------------------
//  Ports:
//    clk, rst_n                      clock, asynchronous active-low reset
//    in_valid / in_ready             upstream handshake (decode)
//    rs1_addr, rs2_addr, rd_addr     register indices
//    rs1_data, rs2_data, imm         operand sources
//    use_imm                         b selects imm instead of rs2
//    alu_ctrl_in, reg_write_in       control passed downstream
//    flush                           kill held and incoming instruction
//    exmem_*/memwb_*                 forwarding sources (we, rd, result)
//    out_valid / out_ready           downstream handshake (execute)
//    a, b, alu_ctrl                  ALU operands and operation
//    rd_out, reg_write_out           destination and gated write enable
// ============================================================================
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [RA_W-1:0] rs1_addr,
   input  logic [RA_W-1:0] rs2_addr,
   input  logic [RA_W-1:0] rd_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic            use_imm,
   input  logic [3:0]      alu_ctrl_in,
   input  logic            reg_write_in,
   input  logic            flush,
   input  logic            exmem_we,
   input  logic            memwb_we,
   input  logic [RA_W-1:0] exmem_rd,
   input  logic [RA_W-1:0] memwb_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [XLEN-1:0] memwb_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] a,
   output logic [XLEN-1:0] b,
   output logic [3:0]      alu_ctrl,
   output logic [RA_W-1:0] rd_out,
   output logic            reg_write_out
);

   // Held instruction state
   logic            valid_q,     valid_d;
   logic [RA_W-1:0] rs1_addr_q,  rs1_addr_d;
   logic [RA_W-1:0] rs2_addr_q,  rs2_addr_d;
   logic [RA_W-1:0] rd_q,        rd_d;
   logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
   logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
   logic [XLEN-1:0] imm_q,       imm_d;
   logic            use_imm_q,   use_imm_d;
   logic [3:0]      alu_ctrl_q,  alu_ctrl_d;
   logic            reg_write_q, reg_write_d;

   // Operand values after the forwarding mux
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   logic capture;
   logic holding;

`ifdef ID_EX_FORWARD_EN
   // EX/MEM is the younger producer, so it wins over MEM/WB. x0 is hardwired
   // to zero and must never pick up a forwarded value.
   always_comb begin
      fwd_rs1 = rs1_data_q;
      fwd_rs2 = rs2_data_q;
      if (exmem_we && (exmem_rd != '0) && (exmem_rd == rs1_addr_q))
         fwd_rs1 = exmem_result;
      else if (memwb_we && (memwb_rd != '0) && (memwb_rd == rs1_addr_q))
         fwd_rs1 = memwb_result;
      if (exmem_we && (exmem_rd != '0) && (exmem_rd == rs2_addr_q))
         fwd_rs2 = exmem_result;
      else if (memwb_we && (memwb_rd != '0) && (memwb_rd == rs2_addr_q))
         fwd_rs2 = memwb_result;
   end
`else
   assign fwd_rs1 = rs1_data_q;
   assign fwd_rs2 = rs2_data_q;

   // Forwarding ports and held addresses have no function in this build.
   logic unused_fwd;
   assign unused_fwd = ^{exmem_we, memwb_we, exmem_rd, memwb_rd,
                         exmem_result, memwb_result, rs1_addr_q, rs2_addr_q};
`endif

   assign in_ready = !valid_q || out_ready;
   assign capture  = in_valid && in_ready && !flush;
   assign holding  = valid_q && !out_ready;

   always_comb begin
      valid_d     = valid_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      rd_d        = rd_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      use_imm_d   = use_imm_q;
      alu_ctrl_d  = alu_ctrl_q;
      reg_write_d = reg_write_q;

      if (flush) begin
         // Data registers keep stale contents; only the valid and write
         // enable need clearing to make the instruction harmless.
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
      end else if (capture) begin
         valid_d     = 1'b1;
         rs1_addr_d  = rs1_addr;
         rs2_addr_d  = rs2_addr;
         rd_d        = rd_addr;
         rs1_data_d  = rs1_data;
         rs2_data_d  = rs2_data;
         imm_d       = imm;
         use_imm_d   = use_imm;
         alu_ctrl_d  = alu_ctrl_in;
         reg_write_d = reg_write_in;
      end else if (holding) begin
`ifdef ID_EX_FORWARD_EN
         // Producers may retire out of the forwarding window while we are
         // stalled; latch their results now so they are not lost.
         rs1_data_d = fwd_rs1;
         rs2_data_d = fwd_rs2;
`endif
      end else if (valid_q) begin
         // Consumed with nothing new arriving.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         rd_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         use_imm_q   <= 1'b0;
         alu_ctrl_q  <= 4'b0000;
         reg_write_q <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         rd_q        <= rd_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         use_imm_q   <= use_imm_d;
         alu_ctrl_q  <= alu_ctrl_d;
         reg_write_q <= reg_write_d;
      end
   end

   assign out_valid     = valid_q;
   assign a             = fwd_rs1;
   assign b             = use_imm_q ? imm_q : fwd_rs2;
   assign alu_ctrl      = alu_ctrl_q;
   assign rd_out        = rd_q;
   assign reg_write_out = valid_q && reg_write_q;

endmodule
`default_nettype wire
